// File: rtl/tiled_mma_accumulator_if.sv
// Bundle of the command, operand and result channels of tiled_mma_accumulator.
//   cmd_valid_i/cmd_ready_o/cmd_tiles_i/C_i : command beat (tile count + initial C tile)
//   op_valid_i/op_ready_o/A_i/B_i           : operand beat (one K-slice of A and B)
//   flush_i                                 : synchronous abort of the current job
//   valid_o/ready_i/D_o                     : result beat
//   tile_cnt_o                              : operand beats accepted in the current job
//   state_o                                 : FSM state, for debug and checkers
// Every channel transfers on a rising clock edge where valid and ready are both
// high; valid never waits for ready, and a producer keeps its payload stable
// while valid is high and ready is low.
interface tiled_mma_accumulator_if #(
    parameter int M         = 4,
    parameter int N         = 4,
    parameter int KT        = 4,
    parameter int P         = 8,
    parameter int MAX_TILES = 16
) ();
    localparam int TW = $clog2(MAX_TILES + 1);

    logic                            cmd_valid_i;
    logic                            cmd_ready_o;
    logic [TW-1:0]                   cmd_tiles_i;
    logic [M-1:0][N-1:0][4*P-1:0]    C_i;
    logic                            op_valid_i;
    logic                            op_ready_o;
    logic [M-1:0][KT-1:0][P-1:0]     A_i;
    logic [KT-1:0][N-1:0][P-1:0]     B_i;
    logic                            flush_i;
    logic                            valid_o;
    logic                            ready_i;
    logic [M-1:0][N-1:0][4*P-1:0]    D_o;
    logic [TW-1:0]                   tile_cnt_o;
    logic [1:0]                      state_o;

    modport slave (
        input  cmd_valid_i, cmd_tiles_i, C_i, op_valid_i, A_i, B_i, flush_i, ready_i,
        output cmd_ready_o, op_ready_o, valid_o, D_o, tile_cnt_o, state_o
    );

    modport master (
        output cmd_valid_i, cmd_tiles_i, C_i, op_valid_i, A_i, B_i, flush_i, ready_i,
        input  cmd_ready_o, op_ready_o, valid_o, D_o, tile_cnt_o, state_o
    );
endinterface

// File: rtl/tiled_mma_accumulator.sv
// Output-stationary multiply-accumulate engine.
// A command loads the C tile and a tile count T; T operand beats each add A*B
// (one K-slice) into the accumulator; the result D is then offered once on
// the output handshake.
// Ports: clk_i (rising edge), rst_ni (async active-low), bus (slave modport of
// tiled_mma_accumulator_if carrying all channels plus tile_cnt_o and state_o).
module tiled_mma_accumulator #(
    parameter int M         = 4,
    parameter int N         = 4,
    parameter int KT        = 4,
    parameter int P         = 8,
    parameter int MAX_TILES = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    tiled_mma_accumulator_if.slave        bus
);
    localparam int AW = 4 * P;
    localparam int TW = $clog2(MAX_TILES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                        state_q, state_d;
    logic [M-1:0][N-1:0][AW-1:0]   acc_q, acc_d;
    logic [TW-1:0]                 cnt_q, cnt_d;
    logic [TW-1:0]                 tiles_q, tiles_d;
    // Holds cmd_ready_o low until the first edge after reset release.
    logic                          live_q;

    logic [N-1:0][KT-1:0][P-1:0]   b_t;
    logic [M-1:0][N-1:0][AW-1:0]   mac;
    logic                          cmd_fire, op_fire, out_fire;

    // Exact signed dot product of one A row and one B column, each product
    // sign-extended to the accumulator width before summing.
    function automatic logic [AW-1:0] dot(input logic [KT-1:0][P-1:0] a_row,
                                          input logic [KT-1:0][P-1:0] b_col);
        logic [AW-1:0]         s;
        logic signed [2*P-1:0] prod;
        s = '0;
        for (int k = 0; k < KT; k++) begin
            prod = $signed(a_row[k]) * $signed(b_col[k]);
            s    = s + {{(AW - 2*P){prod[2*P-1]}}, prod};
        end
        return s;
    endfunction

    always_comb begin
        b_t = '0;
        for (int j = 0; j < N; j++)
            for (int k = 0; k < KT; k++)
                b_t[j][k] = bus.B_i[k][j];
    end

    always_comb begin
        mac = '0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                mac[i][j] = acc_q[i][j] + dot(bus.A_i[i], b_t[j]);
    end

    assign bus.cmd_ready_o = live_q && (state_q == IDLE);
    assign bus.op_ready_o  = (state_q == ACCUM);
    assign bus.valid_o     = (state_q == DONE);
    assign bus.D_o         = acc_q;
    assign bus.tile_cnt_o  = cnt_q;
    assign bus.state_o     = state_q;

    assign cmd_fire = bus.cmd_valid_i && bus.cmd_ready_o;
    assign op_fire  = bus.op_valid_i && bus.op_ready_o;
    assign out_fire = bus.valid_o && bus.ready_i;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        tiles_d = tiles_q;
        if (bus.flush_i) begin
            // Abort wins over any handshake in the same cycle.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        acc_d   = bus.C_i;
                        cnt_d   = '0;
                        tiles_d = (bus.cmd_tiles_i > TW'(MAX_TILES)) ? TW'(MAX_TILES)
                                                                      : bus.cmd_tiles_i;
                        state_d = (bus.cmd_tiles_i == '0) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (op_fire) begin
                        acc_d = mac;
                        cnt_d = cnt_q + TW'(1);
                        if (cnt_q + TW'(1) == tiles_q) state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_fire) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            tiles_q <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            tiles_q <= tiles_d;
            live_q  <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tiled_mma_accumulator.sv
module tb_tiled_mma_accumulator;
    localparam int M = 4, N = 4, KT = 4, P = 8, MAX_TILES = 16;
    localparam int W = M * N * 32;
    localparam int MAXB = 20;

    logic clk;
    logic rst_n;

    tiled_mma_accumulator_if #(.M(M), .N(N), .KT(KT), .P(P), .MAX_TILES(MAX_TILES)) bus ();

    tiled_mma_accumulator #(.M(M), .N(N), .KT(KT), .P(P), .MAX_TILES(MAX_TILES)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    // job data for the reference model: signed integers per element
    int c_m [M][N];
    int a_m [MAXB][M][KT];
    int b_m [MAXB][KT][N];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model: D = C + sum over the first te beats of A*B, 32-bit wrap
    function automatic logic [W-1:0] model_d(input int te);
        logic [W-1:0] r;
        int d;
        r = '0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
                d = c_m[i][j];
                for (int b = 0; b < te; b++)
                    for (int k = 0; k < KT; k++)
                        d = d + a_m[b][i][k] * b_m[b][k][j];
                r[(i*N + j)*32 +: 32] = d;
            end
        return r;
    endfunction

    function automatic logic [W-1:0] pack_c();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) r[(i*N + j)*32 +: 32] = c_m[i][j];
        return r;
    endfunction

    function automatic logic [M*KT*P-1:0] pack_a(input int b);
        logic [M*KT*P-1:0] r;
        logic [31:0] v;
        r = '0;
        for (int i = 0; i < M; i++)
            for (int k = 0; k < KT; k++) begin
                v = a_m[b][i][k];
                r[(i*KT + k)*P +: P] = v[P-1:0];
            end
        return r;
    endfunction

    function automatic logic [KT*N*P-1:0] pack_b(input int b);
        logic [KT*N*P-1:0] r;
        logic [31:0] v;
        r = '0;
        for (int k = 0; k < KT; k++)
            for (int j = 0; j < N; j++) begin
                v = b_m[b][k][j];
                r[(k*N + j)*P +: P] = v[P-1:0];
            end
        return r;
    endfunction

    function automatic int rand_s8();
        logic [7:0] v;
        v = 8'($urandom);
        return int'($signed(v));
    endfunction

    task automatic fill_const(input int cv, input int av, input int bv);
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) c_m[i][j] = cv;
        for (int b = 0; b < MAXB; b++)
            for (int x = 0; x < 4; x++)
                for (int y = 0; y < 4; y++) begin
                    a_m[b][x][y] = av;
                    b_m[b][x][y] = bv;
                end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) c_m[i][j] = int'($urandom);
        for (int b = 0; b < MAXB; b++)
            for (int x = 0; x < 4; x++)
                for (int y = 0; y < 4; y++) begin
                    a_m[b][x][y] = rand_s8();
                    b_m[b][x][y] = rand_s8();
                end
    endtask

    // driver tasks: start and end just after a falling edge
    task automatic send_cmd(input int t);
        int n;
        bus.cmd_tiles_i = 5'(t);
        bus.C_i         = pack_c();
        bus.cmd_valid_i = 1'b1;
        n = 0;
        while (!bus.cmd_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("cmd_timeout", W'(bus.cmd_ready_o), W'(1));
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic send_op(input int b, input int gap_max, input bit last);
        int n;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
        bus.A_i        = pack_a(b);
        bus.B_i        = pack_b(b);
        bus.op_valid_i = 1'b1;
        n = 0;
        while (!bus.op_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("op_timeout", W'(bus.op_ready_o), W'(1));
        @(negedge clk);
        bus.op_valid_i = 1'b0;
        check("tile_cnt", W'(bus.tile_cnt_o), W'(b + 1));
        check("valid_lat", W'(bus.valid_o), W'(last));
    endtask

    task automatic get_result(input int hold, input bit poke_cmd);
        int n;
        n = 0;
        while (!bus.valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("valid_timeout", W'(bus.valid_o), W'(1));
        for (int h = 0; h < hold; h++) begin
            bus.ready_i = 1'b0;
            if (poke_cmd) bus.cmd_valid_i = 1'b1;
            @(negedge clk);
            check("hold_D", bus.D_o, exp_q[0]);
            check("hold_valid", W'(bus.valid_o), W'(1));
            if (poke_cmd) check("hold_cmd_ready", W'(bus.cmd_ready_o), W'(0));
        end
        bus.cmd_valid_i = 1'b0;
        bus.ready_i     = 1'b1;
        check("D", bus.D_o, exp_q.pop_front());
        @(negedge clk);
        bus.ready_i = 1'b0;
        check("valid_drop", W'(bus.valid_o), W'(0));
        check("bubble_cmd_ready", W'(bus.cmd_ready_o), W'(1));
    endtask

    task automatic run_job(input int t, input int gap_max, input int hold, input bit poke_cmd);
        int te;
        te = (t > MAX_TILES) ? MAX_TILES : t;
        exp_q.push_back(model_d(te));
        send_cmd(t);
        if (te == 0) begin
            check("t0_valid", W'(bus.valid_o), W'(1));
            check("t0_op_ready", W'(bus.op_ready_o), W'(0));
        end
        for (int b = 0; b < te; b++) send_op(b, gap_max, b == te - 1);
        check("job_tile_cnt", W'(bus.tile_cnt_o), W'(te));
        get_result(hold, poke_cmd);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_tiles_i = '0;
        bus.C_i         = '0;
        bus.op_valid_i  = 1'b0;
        bus.A_i         = '0;
        bus.B_i         = '0;
        bus.flush_i     = 1'b0;
        bus.ready_i     = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_valid", W'(bus.valid_o), W'(0));
        check("rst_cmd_ready", W'(bus.cmd_ready_o), W'(0));
        check("rst_op_ready", W'(bus.op_ready_o), W'(0));
        check("rst_D", bus.D_o, W'(0));
        check("rst_tile_cnt", W'(bus.tile_cnt_o), W'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", W'(bus.cmd_ready_o), W'(1));

        // basic: C=5, T=3, A=1, B=2, back-to-back beats
        fill_const(5, 1, 2);
        run_job(3, 0, 0, 0);

        // wrap cases
        fill_const(32'h7FFF_FFFF, 1, 1);
        run_job(1, 0, 0, 0);
        fill_const(0, -128, -128);
        run_job(1, 0, 0, 0);

        // backpressure with a command poked while DONE
        fill_rand();
        run_job(2, 0, 5, 1);

        // degenerate tile counts
        fill_const(-7, 3, 3);
        run_job(0, 0, 0, 0);
        fill_rand();
        run_job(20, 0, 0, 0);

        // flush during beat 2 of a T=4 job
        fill_rand();
        send_cmd(4);
        send_op(0, 0, 0);
        bus.A_i         = pack_a(1);
        bus.B_i         = pack_b(1);
        bus.op_valid_i  = 1'b1;
        bus.flush_i     = 1'b1;
        @(negedge clk);
        bus.op_valid_i  = 1'b0;
        bus.flush_i     = 1'b0;
        check("flush_tile_cnt", W'(bus.tile_cnt_o), W'(0));
        check("flush_op_ready", W'(bus.op_ready_o), W'(0));
        check("flush_cmd_ready", W'(bus.cmd_ready_o), W'(1));
        check("flush_valid", W'(bus.valid_o), W'(0));
        fill_const(0, 1, 1);
        run_job(1, 0, 0, 0);

        // asynchronous reset in the middle of accumulation
        fill_rand();
        send_cmd(4);
        send_op(0, 0, 0);
        send_op(1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_D", bus.D_o, W'(0));
        check("arst_tile_cnt", W'(bus.tile_cnt_o), W'(0));
        check("arst_op_ready", W'(bus.op_ready_o), W'(0));
        check("arst_valid", W'(bus.valid_o), W'(0));
        check("arst_cmd_ready", W'(bus.cmd_ready_o), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // T=16 with random operand gaps
        fill_rand();
        run_job(16, 4, 0, 0);

        // random jobs
        for (int r = 0; r < 6; r++) begin
            fill_rand();
            run_job($urandom_range(0, 20), 3, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=%0d", n_checks, 0);
        $fatal(1, "timeout");
    end
endmodule
